dm_arbiter: RTL and testbench

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_arbiter_pkg.sv | 39 +++
 rtl/dm_arbiter_rr_arb2.sv | 21 ++
 rtl/dm_arbiter.sv | 176 +++++++++++++++++
 tb/tb_dm_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arbiter_pkg.sv
// dm_arbiter_pkg: shared memory-access constants and request/response records.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package dm_arbiter_pkg;

  // Access width encodings shared by every data-memory client.
  localparam logic [1:0] memWidth1 = 2'd0;
  localparam logic [1:0] memWidth2 = 2'd1;
  localparam logic [1:0] memWidth4 = 2'd2;

  // One latched memory request; id 0 = m0, 1 = m1.
  typedef struct packed {
    logic        id;
    logic        we;
    logic [1:0]  width;
    logic        ext;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dm_req_t;

  // Memory response held for the DONE cycle.
  typedef struct packed {
    logic [31:0] rdata;
    logic        exc;
  } dm_rsp_t;

  // Fixed-priority pick: m0 wins whenever it asks.
  function automatic logic [1:0] prio_gnt(input logic [1:0] req);
    logic [1:0] g;
    g = 2'b00;
    if (req[0]) begin
      g = 2'b01;
    end else if (req[1]) begin
      g = 2'b10;
    end
    return g;
  endfunction

endpackage

// File: rtl/dm_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant, purely combinational.
// Latency: 0 cycles; grant follows req and last in the same cycle.
// Backpressure: none; the caller decides when a grant is consumed.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // On a tie, favour the requester that did not win last time (last=1 means m1 won).
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: two masters sharing one single-port data memory, one access in flight.
// Latency: 3 cycles req-to-ack (IDLE sample, ACCESS, DONE); next grant earliest the cycle after DONE.
// Backpressure: masters hold req with stable attributes until their one-cycle ack; a loser just waits.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [1:0]  m0_width,
  input  logic        m0_ext,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  output logic        m0_exc,

  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [1:0]  m1_width,
  input  logic        m1_ext,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        m1_exc,

  output logic        dm_we,
  output logic        dm_re,
  output logic [1:0]  dm_width,
  output logic        dm_ext,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_exc
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  dm_req_t    cur_req;
  dm_req_t    new_req;
  dm_rsp_t    rsp;
  logic       last_m1;
  logic [1:0] req_vec;
  logic [1:0] rr_gnt;
  logic [1:0] fix_gnt;
  logic [1:0] gnt;
  logic       grant;

  assign req_vec = {m1_req, m0_req};

  rr_arb2 u_rr_arb2 (
    .req  (req_vec),
    .last (last_m1),
    .gnt  (rr_gnt)
  );

  assign fix_gnt = prio_gnt(req_vec);
  assign gnt     = (FIXED_PRIO != 0) ? fix_gnt : rr_gnt;

  // A grant is only taken while idle; requests seen in ACCESS/DONE wait for the next IDLE.
  assign grant = (state == ST_IDLE) && (gnt != 2'b00);

  // Snapshot of the winning master's attributes.
  always_comb begin
    new_req = '0;
    if (gnt[1]) begin
      new_req.id    = 1'b1;
      new_req.we    = m1_we;
      new_req.width = m1_width;
      new_req.ext   = m1_ext;
      new_req.addr  = m1_addr;
      new_req.wdata = m1_wdata;
    end else begin
      new_req.id    = 1'b0;
      new_req.we    = m0_we;
      new_req.width = m0_width;
      new_req.ext   = m0_ext;
      new_req.addr  = m0_addr;
      new_req.wdata = m0_wdata;
    end
  end

  // State register; reset drops straight to IDLE so dm_we/dm_re fall without waiting for a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: exactly one cycle each in ACCESS and DONE, no bypass back into ACCESS.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (grant) state_nxt = ST_ACCESS;
      ST_ACCESS: state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Request latch, last-grant pointer and response capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_req <= '0;
      last_m1 <= 1'b1;
      rsp     <= '0;
    end else begin
      if (grant) begin
        cur_req <= new_req;
        last_m1 <= gnt[1];
      end
      if (state == ST_ACCESS) begin
        rsp.rdata <= dm_rdata;
        rsp.exc   <= dm_exc;
      end
    end
  end

  // Output decode: memory port live only in ACCESS, ack/response only in DONE, zeros elsewhere.
  always_comb begin
    dm_we    = 1'b0;
    dm_re    = 1'b0;
    dm_width = 2'b00;
    dm_ext   = 1'b0;
    dm_addr  = 32'h0;
    dm_wdata = 32'h0;
    m0_ack   = 1'b0;
    m0_rdata = 32'h0;
    m0_exc   = 1'b0;
    m1_ack   = 1'b0;
    m1_rdata = 32'h0;
    m1_exc   = 1'b0;
    case (state)
      ST_ACCESS: begin
        dm_re    = 1'b1;
        dm_we    = cur_req.we;
        dm_width = cur_req.width;
        dm_ext   = cur_req.ext;
        dm_addr  = cur_req.addr;
        dm_wdata = cur_req.wdata;
      end
      ST_DONE: begin
        if (cur_req.id) begin
          m1_ack   = 1'b1;
          m1_rdata = rsp.rdata;
          m1_exc   = rsp.exc;
        end else begin
          m0_ack   = 1'b1;
          m0_rdata = rsp.rdata;
          m0_exc   = rsp.exc;
        end
      end
      default: begin
      end
    endcase
  end

  // Protocol invariants: never two acks, stores always qualify a read cycle, acks are single pulses.
  assert property (@(posedge clk) disable iff (!reset) !(m0_ack && m1_ack));
  assert property (@(posedge clk) disable iff (!reset) dm_we |-> dm_re);
  assert property (@(posedge clk) disable iff (!reset) (m0_ack || m1_ack) |=> !(m0_ack || m1_ack));

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: scoreboard bench driving both arbitration modes of dm_arbiter.
// Latency: masters issue at a negedge; uncontended ack is seen two posedges later.
// Backpressure: master models hold req until ack, then issue their next queued access.
module tb_dm_arbiter;
  import dm_arbiter_pkg::*;

  typedef struct {
    logic        we;
    logic [1:0]  width;
    logic        ext;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    logic [31:0] rdata;
    logic        exc;
  } exp_t;

  logic        clk    = 1'b0;
  logic        reset  = 1'b0;
  logic        sel_fp = 1'b0;
  logic [1:0]  req    = 2'b00;
  logic [1:0]  we     = 2'b00;
  logic [1:0]  ext    = 2'b00;
  logic [1:0]  width [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];

  logic [1:0]  rr_ack, rr_exc, fp_ack, fp_exc;
  logic [31:0] rr_rdata [2];
  logic [31:0] fp_rdata [2];
  logic        rr_dm_we, rr_dm_re, rr_dm_ext, rr_dm_exc;
  logic        fp_dm_we, fp_dm_re, fp_dm_ext, fp_dm_exc;
  logic [1:0]  rr_dm_width, fp_dm_width;
  logic [31:0] rr_dm_addr, rr_dm_wdata, rr_dm_rdata;
  logic [31:0] fp_dm_addr, fp_dm_wdata, fp_dm_rdata;

  logic [1:0]  ack;
  logic [1:0]  exc_m;
  logic [31:0] rdata_m [2];

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          ack_cnt [2];
  int          ack_cyc [2];
  int          issue_cyc [2];
  int          ack0_hist[$];
  logic [1:0]  busy = 2'b00;
  int          we_cnt = 0;
  logic [31:0] w_addr = 32'h0;
  logic [31:0] w_data = 32'h0;
  logic [31:0] re_addr = 32'h0;
  logic [1:0]  re_width = 2'b00;
  txn_t        stim0[$];
  txn_t        stim1[$];
  exp_t        exp0[$];
  exp_t        exp1[$];

  // Memory model: known word at 0x10, address-derived data elsewhere, fault at 0x3000.
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  assign rr_dm_rdata = rr_dm_re ? mem_rd(rr_dm_addr) : 32'h0;
  assign rr_dm_exc   = rr_dm_re && (rr_dm_addr == 32'h3000);
  assign fp_dm_rdata = fp_dm_re ? mem_rd(fp_dm_addr) : 32'h0;
  assign fp_dm_exc   = fp_dm_re && (fp_dm_addr == 32'h3000);

  assign ack        = sel_fp ? fp_ack : rr_ack;
  assign exc_m      = sel_fp ? fp_exc : rr_exc;
  assign rdata_m[0] = sel_fp ? fp_rdata[0] : rr_rdata[0];
  assign rdata_m[1] = sel_fp ? fp_rdata[1] : rr_rdata[1];

  dm_arbiter #(.FIXED_PRIO(0)) u_rr (
    .clk(clk), .reset(reset),
    .m0_req(req[0]), .m0_we(we[0]), .m0_width(width[0]), .m0_ext(ext[0]),
    .m0_addr(addr[0]), .m0_wdata(wdata[0]),
    .m0_ack(rr_ack[0]), .m0_rdata(rr_rdata[0]), .m0_exc(rr_exc[0]),
    .m1_req(req[1]), .m1_we(we[1]), .m1_width(width[1]), .m1_ext(ext[1]),
    .m1_addr(addr[1]), .m1_wdata(wdata[1]),
    .m1_ack(rr_ack[1]), .m1_rdata(rr_rdata[1]), .m1_exc(rr_exc[1]),
    .dm_we(rr_dm_we), .dm_re(rr_dm_re), .dm_width(rr_dm_width), .dm_ext(rr_dm_ext),
    .dm_addr(rr_dm_addr), .dm_wdata(rr_dm_wdata), .dm_rdata(rr_dm_rdata), .dm_exc(rr_dm_exc)
  );

  dm_arbiter #(.FIXED_PRIO(1)) u_fp (
    .clk(clk), .reset(reset),
    .m0_req(req[0]), .m0_we(we[0]), .m0_width(width[0]), .m0_ext(ext[0]),
    .m0_addr(addr[0]), .m0_wdata(wdata[0]),
    .m0_ack(fp_ack[0]), .m0_rdata(fp_rdata[0]), .m0_exc(fp_exc[0]),
    .m1_req(req[1]), .m1_we(we[1]), .m1_width(width[1]), .m1_ext(ext[1]),
    .m1_addr(addr[1]), .m1_wdata(wdata[1]),
    .m1_ack(fp_ack[1]), .m1_rdata(fp_rdata[1]), .m1_exc(fp_exc[1]),
    .dm_we(fp_dm_we), .dm_re(fp_dm_re), .dm_width(fp_dm_width), .dm_ext(fp_dm_ext),
    .dm_addr(fp_dm_addr), .dm_wdata(fp_dm_wdata), .dm_rdata(fp_dm_rdata), .dm_exc(fp_dm_exc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, expv);
    end
  endtask

  function automatic txn_t mk(input logic w, input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    t.we = w; t.width = memWidth4; t.ext = 1'b0; t.addr = a; t.wdata = d;
    return t;
  endfunction

  task automatic issue(input logic m, input txn_t t);
    exp_t e;
    req[m] = 1'b1; we[m] = t.we; width[m] = t.width; ext[m] = t.ext;
    addr[m] = t.addr; wdata[m] = t.wdata;
    e.rdata = mem_rd(t.addr);
    e.exc   = (t.addr == 32'h3000);
    if (m == 1'b0) exp0.push_back(e); else exp1.push_back(e);
    busy[m] = 1'b1;
    issue_cyc[m] = cyc;
  endtask

  task automatic retire(input logic m);
    exp_t e;
    ack_cnt[m]++;
    ack_cyc[m] = cyc;
    req[m] = 1'b0;
    busy[m] = 1'b0;
    if (m == 1'b0) begin
      ack0_hist.push_back(cyc);
      if (exp0.size() == 0) check("m0_ack_unexpected", 32'(ack[0]), 32'd0);
      else begin
        e = exp0.pop_front();
        check("m0_rdata", rdata_m[0], e.rdata);
        check("m0_exc", 32'(exc_m[0]), 32'(e.exc));
      end
    end else begin
      if (exp1.size() == 0) check("m1_ack_unexpected", 32'(ack[1]), 32'd0);
      else begin
        e = exp1.pop_front();
        check("m1_rdata", rdata_m[1], e.rdata);
        check("m1_exc", 32'(exc_m[1]), 32'(e.exc));
      end
    end
  endtask

  // Master models and monitors: sample outputs, retire acks, then drive the next request.
  always @(negedge clk) begin
    if (reset) begin
      if (ack != 2'b00) check("ack_exclusive", 32'(ack[0] & ack[1]), 32'd0);
      if (ack[0]) retire(1'b0);
      if (ack[1]) retire(1'b1);
      if (!busy[0] && stim0.size() != 0) issue(1'b0, stim0.pop_front());
      if (!busy[1] && stim1.size() != 0) issue(1'b1, stim1.pop_front());
      if (!sel_fp && rr_dm_we) begin
        we_cnt++;
        w_addr = rr_dm_addr;
        w_data = rr_dm_wdata;
      end
      if (!sel_fp && rr_dm_re) begin
        re_addr  = rr_dm_addr;
        re_width = rr_dm_width;
      end
    end
  end

  task automatic wait_ack(input logic m, input int target, input string tag);
    int n;
    n = 0;
    while (ack_cnt[m] < target && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (ack_cnt[m] < target) check(tag, ack_cnt[m], target);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1 reset = 1'b0;
    req = 2'b00; busy = 2'b00;
    stim0.delete(); stim1.delete(); exp0.delete(); exp1.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    int b0, b1, n;
    for (int i = 0; i < 2; i++) begin
      width[i] = 2'b00; addr[i] = 32'h0; wdata[i] = 32'h0;
      ack_cnt[i] = 0; ack_cyc[i] = 0; issue_cyc[i] = 0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_m0_ack", 32'(rr_ack[0]), 32'd0);
    check("rst_m1_ack", 32'(rr_ack[1]), 32'd0);
    check("rst_m0_rdata", rr_rdata[0], 32'h0);
    check("rst_dm_re", 32'(rr_dm_re), 32'd0);
    check("rst_dm_we", 32'(rr_dm_we), 32'd0);
    check("rst_dm_addr", rr_dm_addr, 32'h0);
    #1 reset = 1'b1;

    // Tie straight after reset: m0 first, m1 three cycles later
    @(posedge clk);
    stim0.push_back(mk(1'b0, 32'h100, 32'h0));
    stim1.push_back(mk(1'b0, 32'h104, 32'h0));
    wait_ack(1'b1, 1, "tieA_timeout");
    check("tieA_order", ack_cyc[1] - ack_cyc[0], 32'd3);

    // Repeated tie: pointer now says m1 won last, so m0 wins again
    @(posedge clk);
    stim0.push_back(mk(1'b0, 32'h108, 32'h0));
    stim1.push_back(mk(1'b0, 32'h10C, 32'h0));
    wait_ack(1'b1, 2, "tieB_timeout");
    check("tieB_order", ack_cyc[1] - ack_cyc[0], 32'd3);

    // Single m0 load from 0x10
    b0 = ack_cnt[0];
    @(posedge clk);
    stim0.push_back(mk(1'b0, 32'h10, 32'h0));
    wait_ack(1'b0, b0 + 1, "load_timeout");
    check("load_latency", ack_cyc[0] - issue_cyc[0], 32'd2);
    check("load_dm_addr", re_addr, 32'h10);
    check("load_dm_width", 32'(re_width), 32'(memWidth4));

    // Tie after m0 won alone: m1 must go first
    b0 = ack_cnt[0];
    @(posedge clk);
    stim0.push_back(mk(1'b0, 32'h200, 32'h0));
    stim1.push_back(mk(1'b0, 32'h204, 32'h0));
    wait_ack(1'b0, b0 + 1, "tieC_timeout");
    check("tieC_order", ack_cyc[0] - ack_cyc[1], 32'd3);

    // m1 store: exactly one write cycle with the right address and data
    b1 = ack_cnt[1];
    @(posedge clk);
    we_cnt = 0;
    stim1.push_back(mk(1'b1, 32'h2000, 32'h12345678));
    wait_ack(1'b1, b1 + 1, "store_timeout");
    check("store_we_cycles", we_cnt, 32'd1);
    check("store_addr", w_addr, 32'h2000);
    check("store_wdata", w_data, 32'h12345678);

    // Exception at 0x3000 on a load and on a store
    b0 = ack_cnt[0];
    b1 = ack_cnt[1];
    @(posedge clk);
    stim0.push_back(mk(1'b0, 32'h3000, 32'h0));
    stim1.push_back(mk(1'b1, 32'h3000, 32'h55AA55AA));
    wait_ack(1'b0, b0 + 1, "exc0_timeout");
    wait_ack(1'b1, b1 + 1, "exc1_timeout");

    // Reset during ACCESS of a store
    @(posedge clk);
    stim0.push_back(mk(1'b1, 32'h4000, 32'hCAFEF00D));
    n = 0;
    @(negedge clk);
    while (!rr_dm_re && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("acc_dm_we", 32'(rr_dm_we), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("rst_acc_dm_we", 32'(rr_dm_we), 32'd0);
    check("rst_acc_dm_re", 32'(rr_dm_re), 32'd0);
    req = 2'b00; busy = 2'b00;
    stim0.delete(); exp0.delete();
    b0 = ack_cnt[0];
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    repeat (6) @(posedge clk);
    check("rst_no_ack", ack_cnt[0], b0);
    stim0.push_back(mk(1'b0, 32'h20, 32'h0));
    wait_ack(1'b0, b0 + 1, "post_rst_timeout");
    check("post_rst_latency", ack_cyc[0] - issue_cyc[0], 32'd2);

    // Fixed priority: m0 held continuously starves m1
    sel_fp = 1'b1;
    pulse_reset();
    b0 = ack_cnt[0];
    b1 = ack_cnt[1];
    ack0_hist.delete();
    @(posedge clk);
    for (int k = 0; k < 5; k++) stim0.push_back(mk(1'b0, 32'h40 + 32'(4 * k), 32'h0));
    stim1.push_back(mk(1'b0, 32'h80, 32'h0));
    stim1.push_back(mk(1'b0, 32'h84, 32'h0));
    wait_ack(1'b0, b0 + 5, "fp_m0_timeout");
    check("fp_m1_starved", ack_cnt[1], b1);
    check("fp_m0_count", ack0_hist.size(), 32'd5);
    if (ack0_hist.size() >= 5) begin
      for (int k = 1; k < 5; k++) check("fp_m0_interval", ack0_hist[k] - ack0_hist[k-1], 32'd3);
    end
    wait_ack(1'b1, b1 + 2, "fp_m1_timeout");

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t reached, required finish before 100000", $time);
    $fatal(1);
  end

endmodule
